// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER monitor.
package ber_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width for a history of max_lat entries.
  function automatic int lat_w(input int max_lat);
    return (max_lat > 1) ? $clog2(max_lat) : 1;
  endfunction

  // Increment enable for a w-bit saturating counter holding v (w <= 64).
  // Callers add the returned bit so the counter sticks at all-ones.
  function automatic logic sat_inc(input logic [63:0] v, input logic inc, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return inc && (v != lim);
  endfunction

endpackage

// File: rtl/ber_monitor_ref_history.sv
// Reference-bit history: hist[k] is the bit accepted k+1 accepts ago.
// The read is taken from the pre-shift contents so a same-cycle accept
// never disturbs the comparison.
module ber_monitor_ref_history
  import ber_pkg::*;
#(
  parameter  int MAX_LAT = 64,
  localparam int LAT_W   = lat_w(MAX_LAT),
  localparam int FILL_W  = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_valid,
  input  logic             ref_bit,
  input  logic [LAT_W-1:0] idx,
  output logic             rd_bit,
  output logic             rd_ok
);

  logic [MAX_LAT-1:0] hist;
  logic [FILL_W-1:0]  fill;

  // Shift in accepted reference bits; fill saturates at MAX_LAT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (ref_valid) begin
      hist <= {hist[MAX_LAT-2:0], ref_bit};
      if (fill != FILL_W'(MAX_LAT)) fill <= fill + 1'b1;
    end
  end

  // An entry is only meaningful once that many bits have been accepted.
  assign rd_bit = hist[idx];
  assign rd_ok  = fill > FILL_W'(idx);

endmodule

// File: rtl/ber_monitor.sv
// Bit-error-rate monitor: finds decoder latency against the reference
// stream, locks, counts bits/errors, and drops lock on high error density.
module ber_monitor
  import ber_pkg::*;
#(
  parameter  int MAX_LAT     = 64,
  parameter  int LOCK_LEN    = 32,
  parameter  int WIN         = 64,
  parameter  int UNLOCK_ERRS = 8,
  parameter  int CNT_W       = 32,
  localparam int LAT_W       = lat_w(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] lat_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o,
  output logic             lock_loss_o
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam int WCT_W = $clog2(WIN);
  localparam int ERR_W = $clog2(UNLOCK_ERRS + 1);

  state_t           state;
  logic [LAT_W-1:0] cand;
  logic [LAT_W-1:0] idx;
  logic [RUN_W-1:0] run;
  logic [WCT_W-1:0] win_ct;
  logic [ERR_W-1:0] win_err;
  logic [ERR_W-1:0] win_err_nxt;
  logic             rd_bit;
  logic             rd_ok;
  logic             cmp;
  logic             mism;
  logic [CNT_W-1:0] bit_nxt;
  logic [CNT_W-1:0] err_nxt;

  assign idx = (state == LOCKED) ? lat_o : cand;

  ber_monitor_ref_history #(.MAX_LAT(MAX_LAT)) u_hist (
    .clk       (clk),
    .rst       (rst),
    .ref_valid (ref_valid_i),
    .ref_bit   (ref_bit_i),
    .idx       (idx),
    .rd_bit    (rd_bit),
    .rd_ok     (rd_ok)
  );

  // A compare only counts once the history reaches the selected tap.
  assign cmp         = dec_valid_i && rd_ok;
  assign mism        = dec_bit_i ^ rd_bit;
  assign win_err_nxt = win_err + ERR_W'(mism);

  // Saturating next values for the status counters.
  always_comb begin
    bit_nxt = bit_ct_o + CNT_W'(sat_inc(64'(bit_ct_o), 1'b1, CNT_W));
    err_nxt = err_ct_o + CNT_W'(sat_inc(64'(err_ct_o), mism, CNT_W));
  end

  // Search/lock FSM with window tracking and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      cand        <= '0;
      run         <= '0;
      win_ct      <= '0;
      win_err     <= '0;
      locked_o    <= 1'b0;
      lat_o       <= '0;
      lock_loss_o <= 1'b0;
    end else begin
      lock_loss_o <= 1'b0;
      if (cmp) begin
        case (state)
          SEARCH: begin
            if (!mism) begin
              if (run == RUN_W'(LOCK_LEN - 1)) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                lat_o    <= cand;
                run      <= '0;
                win_ct   <= '0;
                win_err  <= '0;
              end else begin
                run <= run + 1'b1;
              end
            end else begin
              run  <= '0;
              cand <= (cand == LAT_W'(MAX_LAT - 1)) ? '0 : cand + 1'b1;
            end
          end
          LOCKED: begin
            // Unlock wins over window roll-over on the same bit.
            if (win_err_nxt >= ERR_W'(UNLOCK_ERRS)) begin
              state       <= SEARCH;
              locked_o    <= 1'b0;
              lock_loss_o <= 1'b1;
              cand        <= '0;
              run         <= '0;
            end else if (win_ct == WCT_W'(WIN - 1)) begin
              win_ct  <= '0;
              win_err <= '0;
            end else begin
              win_ct  <= win_ct + 1'b1;
              win_err <= win_err_nxt;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Bit/error counters: clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (clear_i) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (cmp && state == LOCKED) begin
      bit_ct_o <= bit_nxt;
      err_ct_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ber_monitor.sv
// Scoreboard bench for ber_monitor: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_ber_monitor;

  localparam int MAX_LAT     = 64;
  localparam int LOCK_LEN    = 32;
  localparam int WIN         = 64;
  localparam int UNLOCK_ERRS = 8;
  localparam int CNT_W       = 32;
  localparam int LAT_W       = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ref_valid_i = 1'b0, ref_bit_i = 1'b0;
  logic             dec_valid_i = 1'b0, dec_bit_i = 1'b0;
  logic             clear_i = 1'b0;
  logic             locked_o, lock_loss_o;
  logic [LAT_W-1:0] lat_o;
  logic [CNT_W-1:0] bit_ct_o, err_ct_o;

  always #5 clk = ~clk;

  ber_monitor #(
    .MAX_LAT(MAX_LAT), .LOCK_LEN(LOCK_LEN), .WIN(WIN),
    .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .clear_i(clear_i),
    .locked_o(locked_o), .lat_o(lat_o),
    .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
    .lock_loss_o(lock_loss_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit     lk;
    int     lat;
    longint bc;
    longint ec;
    bit     loss;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state.
  bit     m_hist[$];
  int     m_fill, m_lat, m_cand, m_run, m_wct, m_werr;
  bit     m_lk, m_loss;
  longint m_bc, m_ec;

  function automatic void m_reset();
    m_hist = {};
    for (int i = 0; i < MAX_LAT; i++) m_hist.push_back(1'b0);
    m_fill = 0; m_lat = 0; m_cand = 0; m_run = 0; m_wct = 0; m_werr = 0;
    m_lk = 0; m_loss = 0; m_bc = 0; m_ec = 0;
  endfunction

  function automatic void model(bit rv, bit rb, bit dv, bit db, bit clr);
    longint lim = (longint'(1) << CNT_W) - 1;
    int idx;
    bit c, mm;
    idx = m_lk ? m_lat : m_cand;
    c  = dv && (m_fill > idx);
    mm = db ^ m_hist[idx];
    m_loss = 0;
    if (c && !m_lk) begin
      if (!mm) begin
        m_run++;
        if (m_run == LOCK_LEN) begin
          m_lk = 1; m_lat = m_cand; m_run = 0; m_wct = 0; m_werr = 0;
        end
      end else begin
        m_run = 0;
        m_cand = (m_cand + 1) % MAX_LAT;
      end
    end else if (c && m_lk) begin
      if (m_bc < lim) m_bc++;
      if (mm && m_ec < lim) m_ec++;
      if (m_werr + int'(mm) >= UNLOCK_ERRS) begin
        m_lk = 0; m_loss = 1; m_cand = 0; m_run = 0;
      end else if (m_wct == WIN - 1) begin
        m_wct = 0; m_werr = 0;
      end else begin
        m_wct++; m_werr += int'(mm);
      end
    end
    if (clr) begin m_bc = 0; m_ec = 0; end
    if (rv) begin
      m_hist.push_front(rb);
      void'(m_hist.pop_back());
      if (m_fill < MAX_LAT) m_fill++;
    end
    sb.push_back('{m_lk, m_lat, m_bc, m_ec, m_loss});
  endfunction

  // PRBS7 reference source and a delay line acting as the decoder.
  logic [6:0] lfsr = 7'h7F;
  bit         strm[$];
  int         dly = 5;

  // One cycle: drive at posedge+1, predict, then compare after the edge.
  task automatic step(input bit flip, input bit clr = 1'b0, input bit dv_en = 1'b1);
    bit   rb, dv, db;
    exp_t e;
    rb   = lfsr[6] ^ lfsr[5];
    lfsr = {lfsr[5:0], rb};
    dv   = dv_en && (strm.size() >= dly);
    db   = dv ? (strm[strm.size() - dly] ^ flip) : 1'b0;
    ref_valid_i = 1'b1; ref_bit_i = rb;
    dec_valid_i = dv;   dec_bit_i = db;
    clear_i     = clr;
    model(1'b1, rb, dv, db, clr);
    strm.push_back(rb);
    if (strm.size() > 200) void'(strm.pop_front());
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("locked", 64'(locked_o),    64'(e.lk));
    chk("lat",    64'(lat_o),       64'(e.lat));
    chk("bit_ct", 64'(bit_ct_o),    64'(e.bc));
    chk("err_ct", 64'(err_ct_o),    64'(e.ec));
    chk("loss",   64'(lock_loss_o), 64'(e.loss));
  endtask

  task automatic idle_inputs();
    ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0; clear_i = 0;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after release.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    m_reset();
    sb.delete();
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 64'(locked_o),    64'd0);
    chk({tag, "_lat"},    64'(lat_o),       64'd0);
    chk({tag, "_bit"},    64'(bit_ct_o),    64'd0);
    chk({tag, "_err"},    64'(err_ct_o),    64'd0);
    chk({tag, "_loss"},   64'(lock_loss_o), 64'd0);
  endtask

  task automatic run_to_lock(input string tag, input int budget, output int loss_seen);
    int n = 0;
    loss_seen = 0;
    while (!locked_o && n < budget) begin
      step(1'b0);
      if (lock_loss_o) loss_seen++;
      n++;
    end
    chk({tag, "_lock_in_budget"}, 64'(locked_o), 64'd1);
  endtask

  initial begin
    int ls, n, lk_seen;
    m_reset();
    #12;
    chk_zero("rst");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 1: lock onto a 5-accept delay -> tap 4, no loss pulse.
    run_to_lock("t1", 3000, ls);
    chk("t1_lat", 64'(lat_o), 64'd4);
    chk("t1_noloss", 64'(ls), 64'd0);

    // 2: 1024 counted bits, every 16th flipped.
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1024; i++) step((i % 16) == 15);
    chk("t2_bits", 64'(bit_ct_o), 64'd1024);
    chk("t2_errs", 64'(err_ct_o), 64'd64);
    chk("t2_locked", 64'(locked_o), 64'd1);

    // 3: eight flips inside one window -> single loss pulse, then relock.
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    while (m_wct != 0 && n < 100) begin step(1'b0); n++; end
    for (int i = 0; i < 8; i++) step(1'b1);
    chk("t3_loss", 64'(lock_loss_o), 64'd1);
    chk("t3_unlocked", 64'(locked_o), 64'd0);
    chk("t3_errs", 64'(err_ct_o), 64'd8);
    step(1'b0);
    chk("t3_loss_one_cycle", 64'(lock_loss_o), 64'd0);
    run_to_lock("t3_relock", 3000, ls);
    chk("t3_relat", 64'(lat_o), 64'd4);

    // 4: deepest tap locks; one beyond never does.
    do_reset();
    dly = 64;
    run_to_lock("t4a", 8000, ls);
    chk("t4_lat63", 64'(lat_o), 64'd63);
    do_reset();
    dly = 65;
    lk_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'b0);
      if (locked_o) lk_seen++;
    end
    chk("t4_never_lock", 64'(lk_seen), 64'd0);

    // 5: clear wins over a counted mismatching bit.
    do_reset();
    dly = 5;
    run_to_lock("t5", 3000, ls);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(i == 10 || i == 40 || i == 70);
    chk("t5_bits100", 64'(bit_ct_o), 64'd100);
    chk("t5_errs3", 64'(err_ct_o), 64'd3);
    step(1'b1, 1'b1);
    chk("t5_clr_bits", 64'(bit_ct_o), 64'd0);
    chk("t5_clr_errs", 64'(err_ct_o), 64'd0);
    chk("t5_still_locked", 64'(locked_o), 64'd1);

    // 6: asynchronous reset mid-lock, then relock from an empty history.
    step(1'b0);
    #3 rst = 1'b0;
    #1 chk_zero("t6_async");
    idle_inputs();
    m_reset();
    sb.delete();
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_to_lock("t6", 3000, ls);
    chk("t6_lat", 64'(lat_o), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
